// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs (package)
// Brief    : Shared widths, write-back tag values, ALU sub-op codes and the
//            station state encoding used by the integer execute slots.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  sinst_t;
  typedef logic [1:0]  regtag_t;
  typedef logic [4:0]  regaddr_t;

  localparam regtag_t UNLOCKED   = 2'd0;
  localparam regtag_t ALU_MASTER = 2'd1;
  localparam regtag_t ALU_SALVER = 2'd2;
  localparam regtag_t LOAD_STORE = 2'd3;

  localparam sinst_t ALU_ADD   = 4'd0;
  localparam sinst_t ALU_SUB   = 4'd1;
  localparam sinst_t ALU_SLL   = 4'd2;
  localparam sinst_t ALU_SLT   = 4'd3;
  localparam sinst_t ALU_SLTU  = 4'd4;
  localparam sinst_t ALU_XOR   = 4'd5;
  localparam sinst_t ALU_SRL   = 4'd6;
  localparam sinst_t ALU_SRA   = 4'd7;
  localparam sinst_t ALU_OR    = 4'd8;
  localparam sinst_t ALU_AND   = 4'd9;
  localparam sinst_t ALU_PASSY = 4'd10;
  localparam sinst_t ALU_AUIPC = 4'd11;
  localparam sinst_t ALU_LINK  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // A tag is released by the broadcast bus of the unit that owns that tag.
  function automatic logic tag_hit(input regtag_t tag, input logic e0,
                                   input logic e1, input logic em);
    return ((tag == ALU_MASTER) && e0) || ((tag == ALU_SALVER) && e1) ||
           ((tag == LOAD_STORE) && em);
  endfunction

  function automatic word_t bus_data(input regtag_t tag, input word_t d0,
                                     input word_t d1, input word_t dm);
    word_t r;
    case (tag)
      ALU_MASTER: r = d0;
      ALU_SALVER: r = d1;
      LOAD_STORE: r = dm;
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Purely combinational 32-bit integer execute unit.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
  import cpu_defs::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic [31:0] o_result
);

  logic [4:0]         w_sh;
  logic signed [31:0] w_sra;

  assign w_sh  = i_y[4:0];
  assign w_sra = $signed(i_x) >>> w_sh;

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_x + i_y;
      ALU_SUB:   o_result = i_x - i_y;
      ALU_SLL:   o_result = i_x << w_sh;
      ALU_SLT:   o_result = {31'd0, ($signed(i_x) < $signed(i_y))};
      ALU_SLTU:  o_result = {31'd0, (i_x < i_y)};
      ALU_XOR:   o_result = i_x ^ i_y;
      ALU_SRL:   o_result = i_x >> w_sh;
      ALU_SRA:   o_result = w_sra;
      ALU_OR:    o_result = i_x | i_y;
      ALU_AND:   o_result = i_x & i_y;
      ALU_PASSY: o_result = i_y;
      ALU_AUIPC: o_result = i_pc + i_y;
      ALU_LINK:  o_result = i_pc + 32'd4;
      default:   o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_station.sv
`default_nettype none
// ============================================================================
// Module   : alu_station
// Brief    : Single-entry reservation station + execute stage for one ALU slot.
//            Optional macro ALU_BYPASS_EN: use the current cycle's broadcasts
//            for readiness and operands instead of waiting a cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_station
  import cpu_defs::*;
#(
  parameter logic [1:0] SELF_TAG = 2'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_en_in,
  input  logic [31:0] alu_pc_in,
  input  logic [3:0]  alu_op_in,
  input  logic [1:0]  alu_tagx_in,
  input  logic [1:0]  alu_tagy_in,
  input  logic [1:0]  alu_tagw_in,
  input  logic [31:0] alu_datax_in,
  input  logic [31:0] alu_datay_in,
  input  logic [4:0]  alu_addrw_in,
  input  logic        en_mw0,
  input  logic        en_mw1,
  input  logic        en_mwM,
  input  logic [31:0] write_data0,
  input  logic [31:0] write_data1,
  input  logic [31:0] write_dataM,
  output logic        busy_out,
  output logic        en_mw_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] write_data_out
);

  if (SELF_TAG == UNLOCKED) begin : g_self_tag_check
    $error("alu_station: SELF_TAG must name an execute unit, not UNLOCKED");
  end

  alu_state_t r_state;
  logic        r_busy, r_en_mw;
  logic [4:0]  r_waddr, r_addrw;
  logic [31:0] r_wdata, r_pc, r_datax, r_datay;
  logic [3:0]  r_op;
  logic [1:0]  r_tagx, r_tagy, r_tagw;

  logic        w_hit_x, w_hit_y, w_hit_w;
  logic [31:0] w_bus_x, w_bus_y;
  logic        w_x_rdy, w_y_rdy, w_w_rdy, w_wait_rdy, w_issue_rdy;
  logic [31:0] w_x_val, w_y_val;
  logic [3:0]  w_alu_op;
  logic [31:0] w_alu_pc, w_alu_x, w_alu_y, w_alu_res;

  assign w_hit_x = tag_hit(r_tagx, en_mw0, en_mw1, en_mwM);
  assign w_hit_y = tag_hit(r_tagy, en_mw0, en_mw1, en_mwM);
  assign w_hit_w = tag_hit(r_tagw, en_mw0, en_mw1, en_mwM);
  assign w_bus_x = bus_data(r_tagx, write_data0, write_data1, write_dataM);
  assign w_bus_y = bus_data(r_tagy, write_data0, write_data1, write_dataM);

`ifdef ALU_BYPASS_EN
  assign w_x_rdy = (r_tagx == UNLOCKED) || w_hit_x;
  assign w_y_rdy = (r_tagy == UNLOCKED) || w_hit_y;
  assign w_w_rdy = (r_tagw == UNLOCKED) || w_hit_w;
  assign w_x_val = w_hit_x ? w_bus_x : r_datax;
  assign w_y_val = w_hit_y ? w_bus_y : r_datay;
`else
  // Readiness only from stored tags: the snoop lands one cycle later.
  assign w_x_rdy = (r_tagx == UNLOCKED);
  assign w_y_rdy = (r_tagy == UNLOCKED);
  assign w_w_rdy = (r_tagw == UNLOCKED);
  assign w_x_val = r_datax;
  assign w_y_val = r_datay;
`endif

  assign w_wait_rdy  = w_x_rdy && w_y_rdy && w_w_rdy;
  assign w_issue_rdy = (alu_tagx_in == UNLOCKED) && (alu_tagy_in == UNLOCKED) &&
                       (alu_tagw_in == UNLOCKED);

  // One execute unit serves both the issue-ready and the wake-up paths.
  assign w_alu_op = (r_state == ST_IDLE) ? alu_op_in    : r_op;
  assign w_alu_pc = (r_state == ST_IDLE) ? alu_pc_in    : r_pc;
  assign w_alu_x  = (r_state == ST_IDLE) ? alu_datax_in : w_x_val;
  assign w_alu_y  = (r_state == ST_IDLE) ? alu_datay_in : w_y_val;

  alu_core u_alu_core (
    .i_op     (w_alu_op),
    .i_pc     (w_alu_pc),
    .i_x      (w_alu_x),
    .i_y      (w_alu_y),
    .o_result (w_alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_en_mw <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_op    <= '0;
      r_addrw <= '0;
      r_tagx  <= UNLOCKED;
      r_tagy  <= UNLOCKED;
      r_tagw  <= UNLOCKED;
      r_datax <= '0;
      r_datay <= '0;
    end else begin
      r_en_mw <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (alu_en_in) begin
            r_pc    <= alu_pc_in;
            r_op    <= alu_op_in;
            r_addrw <= alu_addrw_in;
            r_tagx  <= alu_tagx_in;
            r_tagy  <= alu_tagy_in;
            r_tagw  <= alu_tagw_in;
            r_datax <= alu_datax_in;
            r_datay <= alu_datay_in;
            r_busy  <= 1'b1;
            if (w_issue_rdy) begin
              r_wdata <= w_alu_res;
              r_waddr <= alu_addrw_in;
              r_en_mw <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_hit_x) begin
            r_tagx  <= UNLOCKED;
            r_datax <= w_bus_x;
          end
          if (w_hit_y) begin
            r_tagy  <= UNLOCKED;
            r_datay <= w_bus_y;
          end
          if (w_hit_w) begin
            r_tagw <= UNLOCKED;
          end
          if (w_wait_rdy) begin
            r_wdata <= w_alu_res;
            r_waddr <= r_addrw;
            r_en_mw <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out           = r_busy;
  assign en_mw_out          = r_en_mw;
  assign reg_write_addr_out = r_waddr;
  assign write_data_out     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_alu_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_station
// Brief    : Self-checking bench for alu_station: directed cases plus random
//            issue/broadcast traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_station;

`ifdef ALU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_en_in;
  logic [31:0] alu_pc_in;
  logic [3:0]  alu_op_in;
  logic [1:0]  alu_tagx_in, alu_tagy_in, alu_tagw_in;
  logic [31:0] alu_datax_in, alu_datay_in;
  logic [4:0]  alu_addrw_in;
  logic        en_mw0, en_mw1, en_mwM;
  logic [31:0] write_data0, write_data1, write_dataM;
  logic        busy_out, en_mw_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] write_data_out;

  int n_chk  = 0;
  int n_fail = 0;
  int viol_cnt = 0;

  alu_station #(.SELF_TAG(2'd1)) dut (
    .clk(clk), .rst(rst), .alu_en_in(alu_en_in), .alu_pc_in(alu_pc_in),
    .alu_op_in(alu_op_in), .alu_tagx_in(alu_tagx_in), .alu_tagy_in(alu_tagy_in),
    .alu_tagw_in(alu_tagw_in), .alu_datax_in(alu_datax_in),
    .alu_datay_in(alu_datay_in), .alu_addrw_in(alu_addrw_in),
    .en_mw0(en_mw0), .en_mw1(en_mw1), .en_mwM(en_mwM),
    .write_data0(write_data0), .write_data1(write_data1),
    .write_dataM(write_dataM), .busy_out(busy_out), .en_mw_out(en_mw_out),
    .reg_write_addr_out(reg_write_addr_out), .write_data_out(write_data_out)
  );

  always #5 clk = ~clk;

  // Protocol monitor: the allocator must never issue into a busy station.
  always @(posedge clk) begin
    if (!rst && alu_en_in && busy_out) begin
      viol_cnt++;
      $display("protocol checker: issue while busy at %0t", $time);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] pc,
                                          input logic [31:0] x, input logic [31:0] y);
    int          sh;
    int          sx, sy;
    logic [63:0] wide;
    sh = int'(y[4:0]);
    sx = x;
    sy = y;
    case (op)
      0:  return x + y;
      1:  return x - y;
      2:  begin wide = {32'd0, x} * (64'd1 << sh); return wide[31:0]; end
      3:  return (sx < sy) ? 32'd1 : 32'd0;
      4:  return (x < y) ? 32'd1 : 32'd0;
      5:  return x ^ y;
      6:  return x / (32'd1 << sh);
      7:  return x[31] ? ~((~x) / (32'd1 << sh)) : x / (32'd1 << sh);
      8:  return x | y;
      9:  return x & y;
      10: return y;
      11: return pc + y;
      12: return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] pc,
                       input logic [1:0] tx, input logic [1:0] ty, input logic [1:0] tw,
                       input logic [31:0] dx, input logic [31:0] dy, input logic [4:0] aw);
    alu_op_in = op; alu_pc_in = pc; alu_tagx_in = tx; alu_tagy_in = ty;
    alu_tagw_in = tw; alu_datax_in = dx; alu_datay_in = dy; alu_addrw_in = aw;
    alu_en_in = 1'b1;
    tick();
    alu_en_in = 1'b0;
  endtask

  task automatic bus(input logic b0, input logic [31:0] d0, input logic b1,
                     input logic [31:0] d1, input logic bm, input logic [31:0] dm);
    en_mw0 = b0; write_data0 = d0;
    en_mw1 = b1; write_data1 = d1;
    en_mwM = bm; write_dataM = dm;
    tick();
    en_mw0 = 1'b0; en_mw1 = 1'b0; en_mwM = 1'b0;
  endtask

  // Entered one cycle after the trigger; write-back is due after `lat` cycles.
  task automatic expect_wb(input string tag, input logic [31:0] data,
                           input logic [4:0] addr, input int lat);
    for (int i = 1; i < lat; i++) begin
      check({tag, "_early"}, {31'd0, en_mw_out}, 32'd0);
      tick();
    end
    check({tag, "_en"}, {31'd0, en_mw_out}, 32'd1);
    check({tag, "_data"}, write_data_out, data);
    check({tag, "_addr"}, {27'd0, reg_write_addr_out}, {27'd0, addr});
    tick();
    check({tag, "_en_off"}, {31'd0, en_mw_out}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy_out}, 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] pc, dx, dy, mx, my;
    logic [1:0]  tx, ty, tw, px, py, pw;
    logic [4:0]  aw;
    logic        fire [1:3];
    logic [31:0] bd   [1:3];
    logic        done;
    int          cyc;

    rst = 1'b1; alu_en_in = 1'b0; alu_pc_in = '0; alu_op_in = '0;
    alu_tagx_in = '0; alu_tagy_in = '0; alu_tagw_in = '0;
    alu_datax_in = '0; alu_datay_in = '0; alu_addrw_in = '0;
    en_mw0 = 1'b0; en_mw1 = 1'b0; en_mwM = 1'b0;
    write_data0 = '0; write_data1 = '0; write_dataM = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_en", {31'd0, en_mw_out}, 32'd0);
    tick();
    check("idle_busy", {31'd0, busy_out}, 32'd0);

    // ADD with all operands ready
    issue(4'd0, 32'h0, 2'd0, 2'd0, 2'd0, 32'd5, 32'd7, 5'd3);
    check("add_busy", {31'd0, busy_out}, 32'd1);
    expect_wb("add", 32'd12, 5'd3, 1);

    // SUB waiting on load/store broadcast
    issue(4'd1, 32'h0, 2'd3, 2'd0, 2'd0, 32'hDEAD, 32'd1, 5'd5);
    check("sub_wait", {31'd0, en_mw_out}, 32'd0);
    tick();
    check("sub_wait2", {31'd0, en_mw_out}, 32'd0);
    bus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd10);
    expect_wb("sub", 32'd9, 5'd5, LAT);

    // SLTU with two buses in one cycle
    issue(4'd4, 32'h0, 2'd1, 2'd2, 2'd0, 32'd0, 32'd0, 5'd6);
    bus(1'b1, 32'd20, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    expect_wb("sltu", 32'd1, 5'd6, LAT);

    // SRA held back only by the WAW tag
    issue(4'd7, 32'h0, 2'd0, 2'd0, 2'd2, 32'h8000_0000, 32'd4, 5'd7);
    bus(1'b1, 32'd111, 1'b0, 32'd0, 1'b1, 32'd222);
    check("sra_hold", {31'd0, en_mw_out}, 32'd0);
    tick();
    check("sra_hold2", {31'd0, en_mw_out}, 32'd0);
    check("sra_busy", {31'd0, busy_out}, 32'd1);
    bus(1'b0, 32'd0, 1'b1, 32'd123, 1'b0, 32'd0);
    expect_wb("sra", 32'hF800_0000, 5'd7, LAT);

    // Reset while waiting discards the entry
    issue(4'd0, 32'h0, 2'd1, 2'd0, 2'd0, 32'd0, 32'd3, 5'd9);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw_busy", {31'd0, busy_out}, 32'd0);
    check("rstw_data", write_data_out, 32'd0);
    check("rstw_addr", {27'd0, reg_write_addr_out}, 32'd0);
    bus(1'b1, 32'd55, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rstw_nowb", {31'd0, en_mw_out}, 32'd0);
      tick();
    end

    issue(4'd12, 32'h100, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 5'd1);
    expect_wb("link", 32'h104, 5'd1, 1);
    issue(4'd14, 32'h100, 2'd0, 2'd0, 2'd0, 32'd9, 32'd9, 5'd2);
    expect_wb("op14", 32'd0, 5'd2, 1);

    // Second issue while busy must be ignored
    issue(4'd0, 32'h0, 2'd1, 2'd0, 2'd0, 32'd0, 32'd2, 5'd4);
    issue(4'd1, 32'h0, 2'd0, 2'd0, 2'd0, 32'd50, 32'd1, 5'd20);
    check("dbl_nowb", {31'd0, en_mw_out}, 32'd0);
    check("dbl_flag", viol_cnt, 32'd1);
    bus(1'b1, 32'd40, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_wb("dbl", 32'd42, 5'd4, LAT);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15)); pc = $urandom;
      tx = 2'($urandom_range(0, 3)); ty = 2'($urandom_range(0, 3));
      tw = 2'($urandom_range(0, 3));
      dx = $urandom; dy = $urandom; aw = 5'($urandom_range(0, 31));
      issue(op, pc, tx, ty, tw, dx, dy, aw);
      mx = dx; my = dy; px = tx; py = ty; pw = tw;
      if (px == 2'd0 && py == 2'd0 && pw == 2'd0) begin
        expect_wb("rnd_rdy", ref_alu(int'(op), pc, mx, my), aw, 1);
      end else begin
        check("rnd_wait", {31'd0, en_mw_out}, 32'd0);
        cyc = 0; done = 1'b0;
        while (!done) begin
          for (int k = 1; k <= 3; k++) begin
            bd[k] = $urandom;
            if (px == 2'(k) || py == 2'(k) || pw == 2'(k))
              fire[k] = ($urandom_range(0, 1) == 1) || (cyc > 4);
            else
              fire[k] = ($urandom_range(0, 3) == 0);
          end
          if (px != 2'd0 && fire[px]) begin mx = bd[px]; px = 2'd0; end
          if (py != 2'd0 && fire[py]) begin my = bd[py]; py = 2'd0; end
          if (pw != 2'd0 && fire[pw]) pw = 2'd0;
          bus(fire[1], bd[1], fire[2], bd[2], fire[3], bd[3]);
          if (px == 2'd0 && py == 2'd0 && pw == 2'd0) begin
            done = 1'b1;
            expect_wb("rnd", ref_alu(int'(op), pc, mx, my), aw, LAT);
          end else begin
            check("rnd_nowb", {31'd0, en_mw_out}, 32'd0);
          end
          cyc++;
        end
      end
    end
    check("viol_total", viol_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
